// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS main control FSM with memory wait handling.
// Optional perf counters (retired_cnt, stall_cnt) when MIPS_CTRL_PERF_EN is defined.
module mips_mc_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  pc_src,
  output logic        instr_done,
  output logic        illegal,
  output logic        mem_timeout,
  output logic [3:0]  state_o
`ifdef MIPS_CTRL_PERF_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_XOR = 4'd13;

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_IEX    = 4'd8,
    S_IWB    = 4'd9,
    S_BR     = 4'd10,
    S_JMP    = 4'd11
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              tmo_q, tmo_d;
  logic              mem_st;
  logic              wait_inc;
  logic              tmo_hit;

  logic       pc_en_c, iord_c, mem_read_c, mem_write_c;
  logic       ir_write_c, reg_write_c, reg_dst_c, mem_to_reg_c;
  logic       alu_src_a_c, instr_done_c, illegal_c;
  logic [1:0] alu_src_b_c, pc_src_c;
  logic [3:0] alu_ctrl_c;

  // State, wait counter and sticky timeout registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  // Wait counter: counts stalled cycles in memory states, flags timeout
  always_comb begin
    mem_st   = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
               (state_q == S_MEMWR);
    wait_d   = '0;
    wait_inc = 1'b0;
    tmo_hit  = 1'b0;
    tmo_d    = tmo_q;
    if (mem_st && !mem_ready) begin
      if (wait_q == WAIT_LIM) begin
        tmo_hit = 1'b1;
        tmo_d   = 1'b1;
      end else begin
        wait_d   = wait_q + WAIT_W'(1);
        wait_inc = 1'b1;
      end
    end
  end

  // Next-state and Moore outputs (BR pc_en and ready-qualified strobes are Mealy)
  always_comb begin
    state_d      = state_q;
    pc_en_c      = 1'b0;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_ctrl_c   = ALU_AND;
    pc_src_c     = 2'b00;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_ctrl_c  = ALU_ADD;
        alu_src_b_c = 2'b01;
        ir_write_c  = mem_ready;
        pc_en_c     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        alu_ctrl_c  = ALU_ADD;
        unique case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RT:          state_d = S_REX;
          OP_ADDI:        state_d = S_IEX;
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_J:           state_d = S_JMP;
          default: begin
            state_d   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_ctrl_c  = ALU_ADD;
        state_d     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord_c     = 1'b1;
        mem_read_c = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        iord_c       = 1'b1;
        mem_write_c  = 1'b1;
        instr_done_c = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_REX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b00;
        state_d     = S_RWB;
        unique case (funct)
          FN_ADD: alu_ctrl_c = ALU_ADD;
          FN_SUB: alu_ctrl_c = ALU_SUB;
          FN_AND: alu_ctrl_c = ALU_AND;
          FN_OR:  alu_ctrl_c = ALU_OR;
          FN_NOR: alu_ctrl_c = ALU_NOR;
          FN_XOR: alu_ctrl_c = ALU_XOR;
          FN_SLT: alu_ctrl_c = ALU_SLT;
          default: begin
            alu_ctrl_c = ALU_ADD;
            illegal_c  = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_RWB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_IEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_ctrl_c  = ALU_ADD;
        state_d     = S_IWB;
      end
      S_IWB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_BR: begin
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = 2'b00;
        alu_ctrl_c   = ALU_SUB;
        pc_src_c     = 2'b01;
        instr_done_c = 1'b1;
        pc_en_c      = (opcode == OP_BNE) ? ~zero : zero;
        state_d      = S_FETCH;
      end
      S_JMP: begin
        pc_src_c     = 2'b10;
        pc_en_c      = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // A stalled memory access past the limit abandons the instruction
    if (tmo_hit) state_d = S_FETCH;
  end

  // Outputs are held inactive while reset is asserted
  assign pc_en       = rst_n & pc_en_c;
  assign iord        = rst_n & iord_c;
  assign mem_read    = rst_n & mem_read_c;
  assign mem_write   = rst_n & mem_write_c;
  assign ir_write    = rst_n & ir_write_c;
  assign reg_write   = rst_n & reg_write_c;
  assign reg_dst     = rst_n & reg_dst_c;
  assign mem_to_reg  = rst_n & mem_to_reg_c;
  assign alu_src_a   = rst_n & alu_src_a_c;
  assign alu_src_b   = rst_n ? alu_src_b_c : 2'b00;
  assign alu_ctrl    = rst_n ? alu_ctrl_c : 4'd0;
  assign pc_src      = rst_n ? pc_src_c : 2'b00;
  assign instr_done  = rst_n & instr_done_c;
  assign illegal     = rst_n & illegal_c;
  assign mem_timeout = rst_n & tmo_q;
  assign state_o     = rst_n ? state_q : 4'd0;

`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] retired_q, stall_q;

  // Retired-instruction and memory-stall counters, free-running wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (instr_done_c) retired_q <= retired_q + 32'd1;
      if (wait_inc)     stall_q   <= stall_q + 32'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed scoreboard bench for mips_mc_ctrl.
// Define MIPS_CTRL_PERF_EN to also check the perf counters.
module tb_mips_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        pc_en, iord, mem_read, mem_write, ir_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [3:0]  alu_ctrl, state_o;
  logic        instr_done, illegal, mem_timeout;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  mips_mc_ctrl #(.MEM_WAIT_MAX(15), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
    .pc_src(pc_src), .instr_done(instr_done), .illegal(illegal),
    .mem_timeout(mem_timeout), .state_o(state_o)
`ifdef MIPS_CTRL_PERF_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  logic [23:0] obs;
  assign obs = {pc_en, iord, mem_read, mem_write, ir_write, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
                pc_src, instr_done, illegal, mem_timeout, state_o};

  typedef struct {
    string       tag;
    logic [23:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic tmo_exp = 1'b0;

  function automatic logic [23:0] model(
    input logic rst, input logic [3:0] st, input logic [5:0] op,
    input logic [5:0] fn, input logic z, input logic rdy, input logic tmo);
    logic pe, io, mr, mw, irw, rw, rd, m2r, a, dn, il;
    logic [1:0] b, ps;
    logic [3:0] ac;
    pe = 0; io = 0; mr = 0; mw = 0; irw = 0; rw = 0; rd = 0; m2r = 0;
    a = 0; dn = 0; il = 0; b = 0; ps = 0; ac = 0;
    case (st)
      4'd0: begin mr = 1; ac = 2; b = 1; irw = rdy; pe = rdy; end
      4'd1: begin
        b = 3; ac = 2;
        il = !(op inside {6'o43, 6'o53, 6'o00, 6'o10, 6'o04, 6'o05, 6'o02});
      end
      4'd2: begin a = 1; b = 2; ac = 2; end
      4'd3: begin io = 1; mr = 1; end
      4'd4: begin rw = 1; m2r = 1; dn = 1; end
      4'd5: begin io = 1; mw = 1; dn = rdy; end
      4'd6: begin
        a = 1;
        case (fn)
          6'h20: ac = 2;
          6'h22: ac = 6;
          6'h24: ac = 0;
          6'h25: ac = 1;
          6'h27: ac = 12;
          6'h26: ac = 13;
          6'h2A: ac = 7;
          default: begin ac = 2; il = 1; end
        endcase
      end
      4'd7: begin rw = 1; rd = 1; dn = 1; end
      4'd8: begin a = 1; b = 2; ac = 2; end
      4'd9: begin rw = 1; dn = 1; end
      4'd10: begin
        a = 1; ac = 6; ps = 1; dn = 1;
        pe = (op == 6'b000101) ? !z : z;
      end
      4'd11: begin ps = 2; pe = 1; dn = 1; end
      default: ;
    endcase
    if (!rst) return 24'h0;
    return {pe, io, mr, mw, irw, rw, rd, m2r, a, b, ac, ps, dn, il, tmo, st};
  endfunction

  task automatic cyc(input logic [3:0] st, input logic rdy,
                     input string tag);
    exp_t e;
    exp_t g;
    mem_ready = rdy;
    e.tag = tag;
    e.v   = model(rst_n, st, opcode, funct, zero, rdy, tmo_exp);
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    n_cmp++;
    assert (obs === g.v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", g.tag, obs, g.v);
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int n, input logic [31:0] sq,
                     input string tag);
    opcode = op;
    funct  = fn;
    zero   = z;
    for (int i = 0; i < n; i++)
      cyc(sq[4*i +: 4], 1'b1, $sformatf("%s[%0d]", tag, i));
  endtask

  initial begin
    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0;
    zero = 1'b0; mem_ready = 1'b1;

    for (int i = 0; i < 3; i++) cyc(4'd0, 1'b1, $sformatf("rst%0d", i));
    rst_n = 1'b1;

    run(6'b100011, 6'h00, 1'b0, 5, 32'h43210, "lw");
    run(6'b000000, 6'h2A, 1'b0, 4, 32'h7610, "slt");
    run(6'b000000, 6'h22, 1'b0, 4, 32'h7610, "sub");
    run(6'b000000, 6'h27, 1'b0, 4, 32'h7610, "nor");
    run(6'b000000, 6'h3F, 1'b0, 3, 32'h610, "badfn");
    run(6'b001000, 6'h00, 1'b0, 4, 32'h9810, "addi");
    run(6'b000101, 6'h00, 1'b1, 3, 32'hA10, "bne_z1");
    run(6'b000101, 6'h00, 1'b0, 3, 32'hA10, "bne_z0");
    run(6'b000100, 6'h00, 1'b1, 3, 32'hA10, "beq_z1");
    run(6'b000010, 6'h00, 1'b0, 3, 32'hB10, "j");
    run(6'b111111, 6'h00, 1'b0, 2, 32'h10, "badop");
    run(6'b101011, 6'h00, 1'b0, 4, 32'h5210, "sw");

    run(6'b101011, 6'h00, 1'b0, 3, 32'h210, "sww");
    for (int i = 0; i < 3; i++) cyc(4'd5, 1'b0, $sformatf("sww_st%0d", i));
    cyc(4'd5, 1'b1, "sww_rdy");

    run(6'b100011, 6'h00, 1'b0, 3, 32'h210, "lwrst");
    rst_n = 1'b0;
    cyc(4'd3, 1'b1, "lwrst_in");
    rst_n = 1'b1;
    run(6'b100011, 6'h00, 1'b0, 5, 32'h43210, "lw2");

    for (int i = 0; i < 16; i++) cyc(4'd0, 1'b0, $sformatf("fto%0d", i));
    tmo_exp = 1'b1;
    cyc(4'd0, 1'b0, "fto_flag");
    run(6'b000010, 6'h00, 1'b0, 3, 32'hB10, "j_tmo");
    rst_n = 1'b0;
    cyc(4'd0, 1'b1, "tmo_rst");
    rst_n = 1'b1;
    tmo_exp = 1'b0;
    run(6'b001000, 6'h00, 1'b0, 4, 32'h9810, "addi2");

`ifdef MIPS_CTRL_PERF_EN
    rst_n = 1'b0;
    cyc(4'd0, 1'b1, "perf_rst");
    rst_n = 1'b1;
    run(6'b000010, 6'h00, 1'b0, 3, 32'hB10, "pj");
    run(6'b001000, 6'h00, 1'b0, 4, 32'h9810, "paddi");
    run(6'b100011, 6'h00, 1'b0, 3, 32'h210, "plw");
    cyc(4'd3, 1'b0, "plw_w0");
    cyc(4'd3, 1'b0, "plw_w1");
    cyc(4'd3, 1'b1, "plw_rdy");
    cyc(4'd4, 1'b1, "plw_wb");
    n_cmp++;
    assert (retired_cnt === 32'd3) else begin
      n_err++;
      $error("FAIL retired_cnt: observed %0d expected 3", retired_cnt);
    end
    n_cmp++;
    assert (stall_cnt === 32'd2) else begin
      n_err++;
      $error("FAIL stall_cnt: observed %0d expected 2", stall_cnt);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
